// File: rtl/vga_box_renderer.sv
// rtl/vga_box_renderer.sv - 640x480 raster generator drawing four frame-snapshotted boxes.
// Optional hit flash: define HIT_FLASH_EN.
module vga_box_renderer #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BOX_W        = 48,
    parameter int BOX_H        = 32,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 751,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 491
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] posx0,
    input  logic [9:0] posx1,
    input  logic [9:0] posx2,
    input  logic [9:0] posx3,
    input  logic [8:0] posy0,
    input  logic [8:0] posy1,
    input  logic [8:0] posy2,
    input  logic [8:0] posy3,
    input  logic [2:0] color_idx0,
    input  logic [2:0] color_idx1,
    input  logic [2:0] color_idx2,
    input  logic [2:0] color_idx3,
    input  logic [7:0] hits0,
    input  logic [7:0] hits1,
    input  logic [7:0] hits2,
    input  logic [7:0] hits3,
    output logic       frame_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b
);

    localparam logic [9:0]  L_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  L_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  L_HS_START = 10'(H_SYNC_START);
    localparam logic [9:0]  L_HS_END   = 10'(H_SYNC_END);
    localparam logic [9:0]  L_VS_START = 10'(V_SYNC_START);
    localparam logic [9:0]  L_VS_END   = 10'(V_SYNC_END);
    localparam logic [9:0]  L_SCR_W    = 10'(SCREEN_W);
    localparam logic [9:0]  L_SCR_H    = 10'(SCREEN_H);
    localparam logic [10:0] L_BOX_W    = 11'(BOX_W);
    localparam logic [10:0] L_BOX_H    = 11'(BOX_H);
    localparam logic [5:0]  C_BG       = 6'b00_00_01;

    function automatic logic [5:0] f_palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return 6'b11_00_00;
            3'd1:    return 6'b00_11_00;
            3'd2:    return 6'b00_00_11;
            3'd3:    return 6'b11_11_00;
            3'd4:    return 6'b00_11_11;
            3'd5:    return 6'b11_00_11;
            3'd6:    return 6'b11_01_00;
            default: return 6'b10_10_10;
        endcase
    endfunction

    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic [9:0] r_px [4];
    logic [8:0] r_py [4];
    logic [2:0] r_ci [4];
    logic       r_frame_tick;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_de;
    logic [5:0] r_rgb;

    logic [9:0] w_posx [4];
    logic [8:0] w_posy [4];
    logic [2:0] w_cidx [4];
    logic [3:0] w_hit;
    logic [5:0] w_box_rgb [4];
    logic [5:0] w_pix;
    logic       w_de;
    logic       w_snapshot;

    assign w_posx[0] = posx0;      assign w_posx[1] = posx1;
    assign w_posx[2] = posx2;      assign w_posx[3] = posx3;
    assign w_posy[0] = posy0;      assign w_posy[1] = posy1;
    assign w_posy[2] = posy2;      assign w_posy[3] = posy3;
    assign w_cidx[0] = color_idx0; assign w_cidx[1] = color_idx1;
    assign w_cidx[2] = color_idx2; assign w_cidx[3] = color_idx3;

    // Snapshot at the first blanking line so game logic has the whole vblank to update.
    assign w_snapshot = (r_hcnt == 10'd0) && (r_vcnt == L_SCR_H);
    assign w_de       = (r_hcnt < L_SCR_W) && (r_vcnt < L_SCR_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == L_H_LAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == L_V_LAST) ? 10'd0 : r_vcnt + 10'd1;
        end else begin
            r_hcnt <= r_hcnt + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_px[k] <= '0;
                r_py[k] <= '0;
                r_ci[k] <= '0;
            end
        end else if (w_snapshot) begin
            for (int k = 0; k < 4; k++) begin
                r_px[k] <= w_posx[k];
                r_py[k] <= w_posy[k];
                r_ci[k] <= w_cidx[k];
            end
        end
    end

`ifdef HIT_FLASH_EN
    logic [7:0] w_hits [4];
    logic [7:0] r_hits_prev [4];
    logic [2:0] r_flash [4];

    assign w_hits[0] = hits0; assign w_hits[1] = hits1;
    assign w_hits[2] = hits2; assign w_hits[3] = hits3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_hits_prev[k] <= '0;
                r_flash[k]     <= '0;
            end
        end else if (w_snapshot) begin
            for (int k = 0; k < 4; k++) begin
                r_hits_prev[k] <= w_hits[k];
                if (w_hits[k] != r_hits_prev[k])
                    r_flash[k] <= 3'd7;
                else if (r_flash[k] != 3'd0)
                    r_flash[k] <= r_flash[k] - 3'd1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++)
            w_box_rgb[k] = (r_flash[k] != 3'd0) ? 6'b11_11_11 : f_palette(r_ci[k]);
    end
`else
    logic w_unused_hits;
    assign w_unused_hits = ^{hits0, hits1, hits2, hits3};

    always_comb begin
        for (int k = 0; k < 4; k++)
            w_box_rgb[k] = f_palette(r_ci[k]);
    end
`endif

    // 11-bit compare so a box near the right/bottom edge never wraps back to column/line 0.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < 4; k++) begin
            w_hit[k] = ({1'b0, r_hcnt} >= {1'b0, r_px[k]})
                    && ({1'b0, r_hcnt} <  {1'b0, r_px[k]} + L_BOX_W)
                    && ({1'b0, r_vcnt} >= {2'b00, r_py[k]})
                    && ({1'b0, r_vcnt} <  {2'b00, r_py[k]} + L_BOX_H);
        end
    end

    // Walking from box 3 down lets lower indices overwrite higher ones on overlap.
    always_comb begin
        w_pix = C_BG;
        for (int k = 3; k >= 0; k--) begin
            if (w_hit[k])
                w_pix = w_box_rgb[k];
        end
        if (!w_de)
            w_pix = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_tick <= 1'b0;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_de         <= 1'b0;
            r_rgb        <= '0;
        end else begin
            r_frame_tick <= w_snapshot;
            r_hsync      <= !((r_hcnt >= L_HS_START) && (r_hcnt <= L_HS_END));
            r_vsync      <= !((r_vcnt >= L_VS_START) && (r_vcnt <= L_VS_END));
            r_de         <= w_de;
            r_rgb        <= w_pix;
        end
    end

    assign frame_tick = r_frame_tick;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign de         = r_de;
    assign r          = r_rgb[5:4];
    assign g          = r_rgb[3:2];
    assign b          = r_rgb[1:0];

endmodule

// File: tb/tb_vga_box_renderer.sv
// tb/tb_vga_box_renderer.sv - directed checks of vga_box_renderer on a scaled-down raster.
module tb_vga_box_renderer;

    localparam int SW = 80, SH = 30, BW = 12, BH = 6;
    localparam int HT = 100, HSS = 88, HSE = 95, VT = 40, VSS = 33, VSE = 34;
    localparam int FRAME = HT * VT;
`ifdef HIT_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    localparam logic [5:0] RED = 6'b11_00_00, GREEN = 6'b00_11_00, BLUE = 6'b00_00_11;
    localparam logic [5:0] YEL = 6'b11_11_00, MAG = 6'b11_00_11, WHITE = 6'b11_11_11;
    localparam logic [5:0] BG  = 6'b00_00_01;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] posx0, posx1, posx2, posx3;
    logic [8:0] posy0, posy1, posy2, posy3;
    logic [2:0] color_idx0, color_idx1, color_idx2, color_idx3;
    logic [7:0] hits0, hits1, hits2, hits3;
    logic       frame_tick, hsync, vsync, de;
    logic [1:0] r, g, b;

    int n_vec = 0;
    int n_bad = 0;
    int edge_cnt;
    logic [8:0] fb [2][FRAME];
    int n_tick [16], tick_at [16], n_hs [16], n_vs [16], n_de [16];

    vga_box_renderer #(
        .SCREEN_W(SW), .SCREEN_H(SH), .BOX_W(BW), .BOX_H(BH),
        .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .posx0(posx0), .posx1(posx1), .posx2(posx2), .posx3(posx3),
        .posy0(posy0), .posy1(posy1), .posy2(posy2), .posy3(posy3),
        .color_idx0(color_idx0), .color_idx1(color_idx1),
        .color_idx2(color_idx2), .color_idx3(color_idx3),
        .hits0(hits0), .hits1(hits1), .hits2(hits2), .hits3(hits3),
        .frame_tick(frame_tick), .hsync(hsync), .vsync(vsync), .de(de),
        .r(r), .g(g), .b(b)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // Output seen after release edge e belongs to raster position e-1.
    always @(negedge clk) begin
        if (rst_n && edge_cnt > 0) begin
            fb[((edge_cnt - 1) / FRAME) % 2][(edge_cnt - 1) % FRAME] <= {hsync, vsync, de, r, g, b};
            if ((edge_cnt - 1) / FRAME < 16) begin
                n_tick[(edge_cnt - 1) / FRAME] <= n_tick[(edge_cnt - 1) / FRAME] + int'(frame_tick);
                n_hs[(edge_cnt - 1) / FRAME]   <= n_hs[(edge_cnt - 1) / FRAME] + int'(!hsync);
                n_vs[(edge_cnt - 1) / FRAME]   <= n_vs[(edge_cnt - 1) / FRAME] + int'(!vsync);
                n_de[(edge_cnt - 1) / FRAME]   <= n_de[(edge_cnt - 1) / FRAME] + int'(de);
                if (frame_tick) tick_at[(edge_cnt - 1) / FRAME] <= edge_cnt;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] at(input int f, input int h, input int v);
        return fb[f % 2][v * HT + h];
    endfunction

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input int f);
        wait_edge((f + 1) * FRAME + 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            n_tick[i] = 0; tick_at[i] = 0; n_hs[i] = 0; n_vs[i] = 0; n_de[i] = 0;
        end
        posx0 = 10'd20; posy0 = 9'd10; color_idx0 = 3'd2;
        posx1 = 10'd40; posy1 = 9'd10; color_idx1 = 3'd1;
        posx2 = 10'd30; posy2 = 9'd10; color_idx2 = 3'd3;
        posx3 = 10'd75; posy3 = 9'd27; color_idx3 = 3'd5;
        hits0 = 8'd0; hits1 = 8'd0; hits2 = 8'd0; hits3 = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_outputs", {frame_tick, hsync, vsync, de, r, g, b}, {1'b0, 1'b1, 1'b1, 1'b0, 6'd0});
        @(negedge clk) rst_n = 1'b1;

        wait_frame(0);
        check_val("f0_tick_count", n_tick[0], 1);
        check_val("f0_tick_edge", tick_at[0], SH * HT + 1);
        check_val("f0_hsync_low", n_hs[0], (HSE - HSS + 1) * VT);
        check_val("f0_vsync_low", n_vs[0], (VSE - VSS + 1) * HT);
        check_val("f0_de_count", n_de[0], SW * SH);
        check_val("f0_hs_87", at(0, 87, 0)[8], 1);
        check_val("f0_hs_88", at(0, 88, 0)[8], 0);
        check_val("f0_hs_95", at(0, 95, 0)[8], 0);
        check_val("f0_hs_96", at(0, 96, 0)[8], 1);
        check_val("f0_box_00", at(0, 0, 0)[5:0], RED);
        check_val("f0_box_11_5", at(0, 11, 5)[5:0], RED);
        check_val("f0_bg_12_0", at(0, 12, 0)[5:0], BG);
        check_val("f0_bg_0_6", at(0, 0, 6)[5:0], BG);
        check_val("f0_bg_20_10", at(0, 20, 10)[5:0], BG);

        // Moves during frame 1 (raster ~line 9) must not show until frame 2.
        wait_edge(FRAME + 1000);
        posx3 = 10'd0; color_idx0 = 3'd0;

        wait_frame(1);
        check_val("f1_bg_0_0", at(1, 0, 0)[5:0], BG);
        check_val("f1_blue_20_10", at(1, 20, 10)[5:0], BLUE);
        check_val("f1_bg_19_10", at(1, 19, 10)[5:0], BG);
        check_val("f1_blue_31_15", at(1, 31, 15)[5:0], BLUE);
        check_val("f1_bg_20_16", at(1, 20, 16)[5:0], BG);
        check_val("f1_prio02_30_10", at(1, 30, 10)[5:0], BLUE);
        check_val("f1_yel_32_10", at(1, 32, 10)[5:0], YEL);
        check_val("f1_prio12_40_10", at(1, 40, 10)[5:0], GREEN);
        check_val("f1_green_51_15", at(1, 51, 15)[5:0], GREEN);
        check_val("f1_bg_52_10", at(1, 52, 10)[5:0], BG);
        check_val("f1_mag_75_27", at(1, 75, 27)[5:0], MAG);
        check_val("f1_mag_79_29", at(1, 79, 29)[5:0], MAG);
        check_val("f1_bg_74_27", at(1, 74, 27)[5:0], BG);
        check_val("f1_nowrap_0_27", at(1, 0, 27)[5:0], BG);
        check_val("f1_clip_80_27", at(1, 80, 27)[6:0], 7'd0);

        wait_edge(2 * FRAME + 1000);
        hits0 = 8'd1;

        wait_frame(2);
        check_val("f2_mag_0_27", at(2, 0, 27)[5:0], MAG);
        check_val("f2_mag_11_29", at(2, 11, 29)[5:0], MAG);
        check_val("f2_bg_12_27", at(2, 12, 27)[5:0], BG);
        check_val("f2_bg_75_27", at(2, 75, 27)[5:0], BG);
        check_val("f2_red_20_10", at(2, 20, 10)[5:0], RED);

        for (int f = 3; f <= 10; f++) begin
            wait_frame(f);
            check_val($sformatf("f%0d_box0", f), at(f, 20, 10)[5:0], (FLASH && f <= 9) ? WHITE : RED);
            check_val($sformatf("f%0d_box1", f), at(f, 45, 12)[5:0], GREEN);
        end

        wait_edge(11 * FRAME + 20 * HT + 50);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_outputs", {frame_tick, hsync, vsync, de, r, g, b}, {1'b0, 1'b1, 1'b1, 1'b0, 6'd0});
        repeat (2) @(posedge clk);
        #1;
        check_val("midrst_hold", {frame_tick, hsync, vsync, de, r, g, b}, {1'b0, 1'b1, 1'b1, 1'b0, 6'd0});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("restart_00", {frame_tick, hsync, vsync, de, r, g, b}, {1'b0, 1'b1, 1'b1, 1'b1, RED});
        repeat (87) @(posedge clk);
        #1;
        check_val("restart_hs_87", hsync, 1);
        @(posedge clk);
        #1;
        check_val("restart_hs_88", hsync, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
